shift_sequencer: RTL

//   Multi-step shift controller wrapping the single-step 8-bit shifter
//   (LA = arithmetic, LR = right). Accepts operand + amount + mode over a

---
 rtl/shift_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts an operand/amount/mode, drives the
// external single-step shifter one bit per clock, then presents the result.
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [7:0]       A_in,
    input  logic             LA_in,
    input  logic             LR_in,
    input  logic [AMT_W-1:0] AMT,
    input  logic             abort,
    output logic [7:0]       sh_A,
    output logic             sh_LA,
    output logic             sh_LR,
    input  logic [7:0]       sh_Y,
    input  logic             sh_C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       Y_out,
    output logic             C_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = 1;

    state_t           state;
    state_t           state_next;
    logic [7:0]       work;
    logic             la_q;
    logic             lr_q;
    logic [AMT_W-1:0] cnt;
    logic             carry;
    logic             accept;

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign accept      = start_valid & start_ready;

    assign sh_A  = work;
    assign sh_LA = la_q;
    assign sh_LR = lr_q;
    assign Y_out = work;
    assign C_out = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort takes priority over both stepping and result consumption.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (AMT != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            la_q  <= 1'b0;
            lr_q  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                work  <= A_in;
                la_q  <= LA_in;
                lr_q  <= LR_in;
                cnt   <= AMT;
                carry <= 1'b0;
            end else if (state == SHIFT && !abort) begin
                work  <= sh_Y;
                carry <= sh_C;
                cnt   <= cnt - CNT_ONE;
            end
        end
    end

endmodule
